// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor family.
package bp_pkg;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_e;

    // Weakly-not-taken counter value for a CTR_BITS-wide counter.
    function automatic int unsigned weak_nt(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

    // Callers pass zero-extended index/history and truncate to their index width.
    function automatic logic [31:0] gshare_hash(input logic [31:0] index,
                                                input logic [31:0] hist);
        return index ^ hist;
    endfunction

endpackage

// File: rtl/sat_ctr_update.sv
// sat_ctr_update: combinational saturating up/down counter step.
module sat_ctr_update #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_BITS'(1);
        end else begin
            if (ctr_i != CTR_MIN) ctr_o = ctr_i - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: PHT indexed by PC index XOR GHR, with a post-reset clear sweep.
// Define GSHARE_STATS_EN to add saturating stat_preds / stat_mispreds counters.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned HIST_BITS  = 8,
    parameter int unsigned CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  pred_req,
    input  logic [INDEX_BITS-1:0] pc_index,
    output logic                  predict_taken,
    output logic [HIST_BITS-1:0]  predict_hist,
    input  logic                  update_en,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic [HIST_BITS-1:0]  update_hist,
    input  logic                  update_taken,
    input  logic                  update_mispredict
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]           stat_preds,
    output logic [31:0]           stat_mispreds
`endif
);

    localparam int unsigned           N        = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0]   WEAK_NT  = CTR_BITS'(weak_nt(CTR_BITS));
    localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;

    bp_state_e               state_q, state_d;
    logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
    logic [HIST_BITS-1:0]    ghr_q, ghr_d;
    logic [CTR_BITS-1:0]     pht_q [N];

    logic                    run;
    logic [INDEX_BITS-1:0]   rd_idx;
    logic [INDEX_BITS-1:0]   upd_idx;
    logic [CTR_BITS-1:0]     rd_ctr;
    logic [CTR_BITS-1:0]     upd_ctr_old;
    logic [CTR_BITS-1:0]     upd_ctr_new;

    assign run         = (state_q == BP_RUN);
    assign rd_idx      = INDEX_BITS'(gshare_hash(32'(pc_index), 32'(ghr_q)));
    assign upd_idx     = INDEX_BITS'(gshare_hash(32'(update_index), 32'(update_hist)));
    assign rd_ctr      = pht_q[rd_idx];
    assign upd_ctr_old = pht_q[upd_idx];

    assign ready         = run;
    assign predict_taken = run && rd_ctr[CTR_BITS-1];
    assign predict_hist  = ghr_q;

    sat_ctr_update #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_ctr (
        .ctr_i   (upd_ctr_old),
        .taken_i (update_taken),
        .ctr_o   (upd_ctr_new)
    );

    // Sweep FSM: one entry per cycle, then RUN until the next reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == BP_INIT) begin
            ptr_d = ptr_q + INDEX_BITS'(1);
            if (ptr_q == PTR_LAST) state_d = BP_RUN;
        end
    end

    // Mispredict repair wins over the speculative shift of the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (run) begin
            if (update_en && update_mispredict) begin
                ghr_d = HIST_BITS'({update_hist, update_taken});
            end else if (pred_req) begin
                ghr_d = HIST_BITS'({ghr_q, predict_taken});
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BP_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    // Table storage has no reset; the sweep is the only clear.
    always_ff @(posedge clk) begin
        if (state_q == BP_INIT) begin
            pht_q[ptr_q] <= WEAK_NT;
        end else if (update_en) begin
            pht_q[upd_idx] <= upd_ctr_new;
        end
    end

`ifdef GSHARE_STATS_EN
    logic [31:0] stat_preds_q, stat_preds_d;
    logic [31:0] stat_mispreds_q, stat_mispreds_d;

    always_comb begin
        stat_preds_d    = stat_preds_q;
        stat_mispreds_d = stat_mispreds_q;
        if (run && pred_req && (stat_preds_q != 32'hFFFF_FFFF)) begin
            stat_preds_d = stat_preds_q + 32'd1;
        end
        if (run && update_en && update_mispredict && (stat_mispreds_q != 32'hFFFF_FFFF)) begin
            stat_mispreds_d = stat_mispreds_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_preds_q    <= '0;
            stat_mispreds_q <= '0;
        end else begin
            stat_preds_q    <= stat_preds_d;
            stat_mispreds_q <= stat_mispreds_d;
        end
    end

    assign stat_preds    = stat_preds_q;
    assign stat_mispreds = stat_mispreds_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: randomized and directed checks against a table/arithmetic model.
// Build with +define+GSHARE_STATS_EN to include the statistics scenario.
module tb_gshare_predictor;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic       pred_req;
    logic [7:0] pc_index;
    logic       predict_taken;
    logic [7:0] predict_hist;
    logic       update_en;
    logic [7:0] update_index;
    logic [7:0] update_hist;
    logic       update_taken;
    logic       update_mispredict;
`ifdef GSHARE_STATS_EN
    logic [31:0] stat_preds;
    logic [31:0] stat_mispreds;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: counters as plain integers 0..3, history as an integer 0..255.
    int m_pht [N];
    int m_ghr;
    int m_ptr;
    bit m_run;

    gshare_predictor dut (
        .clk               (clk),
        .reset             (reset),
        .ready             (ready),
        .pred_req          (pred_req),
        .pc_index          (pc_index),
        .predict_taken     (predict_taken),
        .predict_hist      (predict_hist),
        .update_en         (update_en),
        .update_index      (update_index),
        .update_hist       (update_hist),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict)
`ifdef GSHARE_STATS_EN
        ,
        .stat_preds        (stat_preds),
        .stat_mispreds     (stat_mispreds)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_pred(input int pc);
        return m_run && (m_pht[(pc ^ m_ghr) % N] >= 2);
    endfunction

    task automatic idle_inputs();
        pred_req          = 1'b0;
        pc_index          = 8'h00;
        update_en         = 1'b0;
        update_index      = 8'h00;
        update_hist       = 8'h00;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    // Advance model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        bit p;
        int u;
        if (!m_run) begin
            m_pht[m_ptr] = 1;
            m_ptr = m_ptr + 1;
            if (m_ptr == N) m_run = 1'b1;
        end else begin
            p = m_pred(int'(pc_index));
            if (update_en) begin
                u = int'(update_index) ^ int'(update_hist);
                if (update_taken) m_pht[u] = (m_pht[u] == 3) ? 3 : m_pht[u] + 1;
                else              m_pht[u] = (m_pht[u] == 0) ? 0 : m_pht[u] - 1;
            end
            if (update_en && update_mispredict)
                m_ghr = (int'(update_hist) * 2 + int'(update_taken)) % N;
            else if (pred_req)
                m_ghr = (m_ghr * 2 + int'(p)) % N;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        m_run = 1'b0;
        m_ptr = 0;
        m_ghr = 0;
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i <= N; i++) begin
            vectors++;
            if (ready !== (i >= N)) begin
                miscompares++;
                $display("FAIL %s_ready cycle %0d: got %b expected %b", tag, i, ready, (i >= N));
            end
            if (i < N) begin
                pred_req     = 1'($urandom_range(0, 1));
                pc_index     = 8'($urandom);
                update_en    = 1'($urandom_range(0, 1));
                update_index = 8'($urandom);
                update_hist  = 8'($urandom);
                update_taken = 1'($urandom_range(0, 1));
                update_mispredict = 1'($urandom_range(0, 1));
                #1;
                if (i % 32 == 5) begin
                    vectors++;
                    if (predict_taken !== 1'b0 || predict_hist !== 8'h00) begin
                        miscompares++;
                        $display("FAIL %s_init_outputs cycle %0d: taken %b hist %h expected 0 00",
                                 tag, i, predict_taken, predict_hist);
                    end
                end
                tick();
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        assert_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (ready !== 1'b0 || predict_hist !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: ready %b hist %h expected 0 00", ready, predict_hist);
        end
        reset = 1'b0;
        sweep_check("reset");
        for (int k = 0; k < 16; k++) begin
            pc_index = 8'($urandom);
            #1;
            vectors++;
            if (predict_taken !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_read pc %h: got %b expected 0", pc_index, predict_taken);
            end
        end
        idle_inputs();
    endtask

    task automatic test_counter();
        bit exp_seq [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bit taken_seq [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int s = 0; s < 9; s++) begin
            update_en    = 1'b1;
            update_index = 8'h3C;
            update_hist  = 8'h00;
            update_taken = taken_seq[s];
            tick();
            update_en = 1'b0;
            pc_index  = 8'h3C;
            #1;
            vectors++;
            if (predict_taken !== exp_seq[s] || predict_taken !== m_pred(32'h3C)) begin
                miscompares++;
                $display("FAIL counter step %0d: got %b expected %b", s, predict_taken, exp_seq[s]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_ghr_shift();
        logic [7:0] train [3] = '{8'h10, 8'h20, 8'h00};
        logic [7:0] pcs   [3] = '{8'h10, 8'h21, 8'h50};
        bit         exp_p [3] = '{1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            repeat (2) begin
                update_en = 1'b1; update_index = train[t]; update_hist = 8'h00; update_taken = 1'b1;
                tick();
            end
        end
        idle_inputs();
        for (int s = 0; s < 3; s++) begin
            pred_req = 1'b1;
            pc_index = pcs[s];
            #1;
            vectors++;
            if (predict_taken !== exp_p[s]) begin
                miscompares++;
                $display("FAIL ghr_pred step %0d: got %b expected %b", s, predict_taken, exp_p[s]);
            end
            tick();
        end
        idle_inputs();
        vectors++;
        if (predict_hist !== 8'h06 || int'(predict_hist) != m_ghr) begin
            miscompares++;
            $display("FAIL ghr_shift: got %h expected 06", predict_hist);
        end
        pc_index = 8'h06;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL ghr_hash pc 06: got %b expected 1 (entry 00)", predict_taken);
        end
    endtask

    task automatic test_repair();
        pred_req = 1'b1; pc_index = 8'h10;
        update_en = 1'b1; update_mispredict = 1'b1; update_index = 8'h00;
        update_hist = 8'hA5; update_taken = 1'b0;
        tick();
        idle_inputs();
        vectors++;
        if (predict_hist !== 8'h4A) begin
            miscompares++;
            $display("FAIL repair_priority: got %h expected 4a", predict_hist);
        end
        update_mispredict = 1'b1; update_hist = 8'hFF; update_taken = 1'b1;
        tick();
        idle_inputs();
        vectors++;
        if (predict_hist !== 8'h4A) begin
            miscompares++;
            $display("FAIL mispredict_without_en: got %h expected 4a", predict_hist);
        end
    endtask

    task automatic test_back_to_back();
        // Same-cycle read/update of entry 0x77^0x4A = 0x3D, which is still weak NT.
        pc_index = 8'h77;
        update_en = 1'b1; update_index = 8'h77; update_hist = 8'h4A; update_taken = 1'b1;
        #1;
        vectors++;
        if (predict_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_old_value: got %b expected 0", predict_taken);
        end
        tick();
        update_en = 1'b0;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL update_next_cycle: got %b expected 1", predict_taken);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            pred_req          = 1'($urandom_range(0, 1));
            pc_index          = 8'($urandom);
            update_en         = ($urandom_range(0, 3) != 0);
            update_index      = 8'($urandom_range(0, 15));
            update_hist       = ($urandom_range(0, 1) == 1) ? predict_hist : 8'($urandom_range(0, 7));
            update_taken      = 1'($urandom_range(0, 1));
            update_mispredict = ($urandom_range(0, 4) == 0);
            #1;
            vectors++;
            if (predict_taken !== m_pred(int'(pc_index)) || int'(predict_hist) != m_ghr) begin
                miscompares++;
                $display("FAIL random cycle %0d: taken %b hist %h expected %b %h",
                         c, predict_taken, predict_hist, m_pred(int'(pc_index)), 8'(m_ghr));
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        update_en = 1'b1; update_mispredict = 1'b1; update_hist = 8'h00; update_taken = 1'b0;
        tick();
        update_mispredict = 1'b0;
        for (int u = 0; u < N; u++) begin
            repeat (3) begin
                update_index = 8'(u); update_taken = 1'b1;
                tick();
            end
        end
        idle_inputs();
        for (int u = 0; u < N; u += 17) begin
            pc_index = 8'(u);
            #1;
            vectors++;
            if (predict_taken !== 1'b1) begin
                miscompares++;
                $display("FAIL prefill entry %0d: got %b expected 1", u, predict_taken);
            end
        end
        assert_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (100) tick();
        assert_reset();
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midsweep_reset_ready: got %b expected 0", ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sweep_check("midsweep");
        for (int u = 0; u < N; u++) begin
            pc_index = 8'(u);
            #1;
            vectors++;
            if (predict_taken !== 1'b0) begin
                miscompares++;
                $display("FAIL midsweep_clear entry %0d: got %b expected 0", u, predict_taken);
            end
        end
        // 01 becomes 10 after one taken update; 00 would stay not-taken.
        for (int u = 3; u < N; u += 25) begin
            update_en = 1'b1; update_index = 8'(u); update_hist = 8'h00; update_taken = 1'b1;
            tick();
            update_en = 1'b0; pc_index = 8'(u);
            #1;
            vectors++;
            if (predict_taken !== 1'b1 || !m_pred(u)) begin
                miscompares++;
                $display("FAIL midsweep_weak_nt entry %0d: got %b expected 1", u, predict_taken);
            end
        end
        idle_inputs();
    endtask

`ifdef GSHARE_STATS_EN
    task automatic test_stats();
        assert_reset();
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (stat_preds !== 32'd0 || stat_mispreds !== 32'd0) begin
            miscompares++;
            $display("FAIL stats_reset: preds %0d mispreds %0d expected 0 0", stat_preds, stat_mispreds);
        end
        for (int i = 0; i < N; i++) begin
            pred_req = 1'b1; update_en = 1'b1; update_mispredict = 1'b1;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            pred_req = 1'b1; pc_index = 8'($urandom);
            tick();
            pred_req = 1'b0;
            if (i < 2) begin
                update_en = 1'b1; update_mispredict = 1'b1; update_hist = 8'($urandom);
                tick();
                update_en = 1'b0; update_mispredict = 1'b0;
            end
        end
        vectors++;
        if (stat_preds !== 32'd5 || stat_mispreds !== 32'd2) begin
            miscompares++;
            $display("FAIL stats_count: preds %0d mispreds %0d expected 5 2", stat_preds, stat_mispreds);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_counter();
        test_ghr_shift();
        test_repair();
        test_back_to_back();
        test_random();
        test_reset_mid_sweep();
`ifdef GSHARE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the bimodal branch predictor in the IF stage; the PHT is indexed by PC index XOR global history register (GHR).
- Adds configurable counter width, speculative GHR update with mispredict repair, and a hardware table-clear sweep after reset.
- Read side feeds the fetch redirect; update side is driven from EX on branch resolution.

Parameters:
- INDEX_BITS, 8, log2 of PHT entries (N = 2^INDEX_BITS).
- HIST_BITS, 8, GHR length; legal range 1..INDEX_BITS.
- CTR_BITS, 2, saturating counter width; legal range 2..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  out  1  high once the PHT clear sweep has completed.
- pred_req  in  1  a branch is being predicted this cycle; the GHR advances.
- pc_index  in  INDEX_BITS  PC-derived index.
- predict_taken  out  1  combinational prediction (counter MSB).
- predict_hist  out  HIST_BITS  current GHR, before any shift; travels down the pipe with the branch.
- update_en  in  1  a branch resolved this cycle.
- update_index  in  INDEX_BITS  PC index of the resolved branch.
- update_hist  in  HIST_BITS  GHR snapshot captured at prediction time.
- update_taken  in  1  actual branch outcome.
- update_mispredict  in  1  the prediction was wrong; repair the GHR.

Behaviour:
- Hash: idx = pc_index XOR zero-extend(ghr). Update hash: uidx = update_index XOR zero-extend(update_hist).
- Init value: WEAK_NT = 2^(CTR_BITS-1) - 1 (2'b01 when CTR_BITS=2).
- FSM states:
  - INIT: the pointer writes WEAK_NT to one entry per cycle, from 0 up to N-1, then moves to RUN. This takes N cycles; ready = 0 throughout.
  - RUN: ready = 1. The FSM never leaves RUN except on reset.
- Async reset, effective immediately:
  - FSM goes to INIT, pointer = 0, ghr = 0, ready = 0.
  - The PHT array itself is not reset; it is cleared only by the sweep.
  - Reset asserted mid-sweep restarts the sweep from entry 0.
- Behaviour in INIT:
  - predict_taken = 0.
  - pred_req and update_en are ignored, so the GHR and PHT are unchanged by them.
- Read (RUN):
  - predict_taken = pht[idx][CTR_BITS-1], combinational.
  - predict_hist = ghr.
- PHT update (RUN, update_en), written at the clock edge:
  - If update_taken, pht[uidx] increments, saturating at 2^CTR_BITS - 1.
  - Otherwise pht[uidx] decrements, saturating at 0.
- Same-cycle read and update of the same entry: the read returns the old value. There is no bypass.
- GHR next value (RUN), by priority:
  1. update_en && update_mispredict: ghr <= {update_hist[HIST_BITS-2:0], update_taken}. This repair overrides any same-cycle pred_req shift. When HIST_BITS=1, ghr <= update_taken.
  2. Else if pred_req: ghr <= {ghr[HIST_BITS-2:0], predict_taken}.
  3. Else ghr holds.
- update_mispredict without update_en has no effect.
- Latency: the prediction is available in the same cycle; an update is visible to reads from the next cycle.

Optional Feature:
- Macro: GSHARE_STATS_EN.
- Defined:
  - Adds outputs stat_preds [31:0] and stat_mispreds [31:0].
  - stat_preds increments on each pred_req in RUN.
  - stat_mispreds increments on each update_en && update_mispredict in RUN.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package bp_pkg contains:
  - FSM state typedef {BP_INIT, BP_RUN}.
  - Function weak_nt(ctr_bits).
  - Function gshare_hash(index, hist) for reuse by future tournament predictors.
- Sub-module sat_ctr_update: purely combinational; takes the old value and taken, returns the saturated next value, parametrised by CTR_BITS. It is shared with the existing bimodal PHT.

Test Plan:
- Reset, then run with defaults: ready = 0 for exactly 256 cycles after reset release, then 1. Reading any index then gives predict_taken = 0.
- After sweep, pc_index=8'h3C, ghr=0: update_en with taken twice at uidx=8'h3C. The next cycle's read of 8'h3C gives predict_taken = 1. Two further taken updates leave the counter at 2'b11 (saturates); three not-taken updates give 2'b00; one more stays 2'b00.
- GHR shift: starting from ghr=8'h00, 3 pred_req cycles with predicted taken, taken, not-taken give predict_hist = 8'h06. Then pc_index=8'h06 hashes to entry 8'h00.
- Repair priority: in the same cycle, pred_req=1 and update_en=1, update_mispredict=1, update_hist=8'hA5, update_taken=0. Next ghr = 8'h4A.
- Reset asserted at sweep cycle 100 with pre-sweep PHT entries set to 2'b11: after re-release the full 256-cycle sweep runs and all entries read 2'b01.
- GSHARE_STATS_EN: 5 pred_req and 2 mispredict updates give stat_preds = 5 and stat_mispreds = 2. Requests issued during INIT are not counted.
